// File: rtl/tmr_pkg.sv
// Shared definitions for the triplicated scrubbed register: default
// parameter values, the scrub counter width helper and the 2-of-3 majority.
package tmr_pkg;

  localparam int unsigned TMR_WIDTH_DEF        = 8;
  localparam int unsigned TMR_SCRUB_PERIOD_DEF = 16;
  localparam int unsigned TMR_CNT_W_DEF        = 8;

  // Width of a counter that must hold 0..period-1; never below one bit.
  function automatic int unsigned scrub_cnt_w(input int unsigned period);
    int unsigned w;
    w = (period <= 2) ? 1 : $clog2(period);
    return w;
  endfunction

  // Single-bit 2-of-3 majority; applied bit by bit by the voter.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 voter, WIDTH bits wide, purely combinational.
module tmr_voter
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH = TMR_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] y_o
);

  // Vote every bit position independently.
  always_comb begin
    y_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y_o[i] = maj3(a_i[i], b_i[i], c_i[i]);
    end
  end

endmodule

// File: rtl/tmr_scrub_reg.sv
// Triplicated WIDTH-bit register with majority voting on inputs, load enable
// and stored value. A free-running scrub counter periodically rewrites all
// three copies with the voted value so one upset copy cannot linger until a
// second upset makes it win the vote. Copy disagreement is reported through a
// sticky flag and, when TMR_ERR_CNT_EN is defined, a saturating cycle count;
// without that macro errCnt reads constant 0 and no counter flops exist.
module tmr_scrub_reg
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH        = TMR_WIDTH_DEF,
  parameter int unsigned SCRUB_PERIOD = TMR_SCRUB_PERIOD_DEF, // must be >= 2
  parameter int unsigned CNT_W        = TMR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  input  logic             ldA,
  input  logic             ldB,
  input  logic             ldC,
  input  logic             errClr,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] outC,
  output logic             errFlag,
  output logic [CNT_W-1:0] errCnt
);

  localparam int unsigned    SCW     = scrub_cnt_w(SCRUB_PERIOD);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCRUB_PERIOD - 1);

  // The three physical copies (regA/regB/regC) and their next states.
  logic [WIDTH-1:0] regA_q, regB_q, regC_q;
  logic [WIDTH-1:0] regA_d, regB_d, regC_d;

  logic [SCW-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic             err_flag_q, err_flag_d;

  logic [WIDTH-1:0] d_v;
  logic [WIDTH-1:0] q_v;
  logic [0:0]       ld_v;
  logic             tick;
  logic             mismatch;

  tmr_voter #(.WIDTH(WIDTH)) u_vote_d (
    .a_i (inA),
    .b_i (inB),
    .c_i (inC),
    .y_o (d_v)
  );

  tmr_voter #(.WIDTH(WIDTH)) u_vote_q (
    .a_i (regA_q),
    .b_i (regB_q),
    .c_i (regC_q),
    .y_o (q_v)
  );

  tmr_voter #(.WIDTH(1)) u_vote_ld (
    .a_i (ldA),
    .b_i (ldB),
    .c_i (ldC),
    .y_o (ld_v)
  );

  assign tick     = (scrub_cnt_q == SC_LAST);
  assign mismatch = |((regA_q ^ regB_q) | (regA_q ^ regC_q));

  // Copy update: a voted load beats a scrub tick; otherwise each copy holds
  // its own value, so an upset persists until the next tick repairs it.
  always_comb begin
    regA_d = regA_q;
    regB_d = regB_q;
    regC_d = regC_q;
    if (ld_v[0]) begin
      regA_d = d_v;
      regB_d = d_v;
      regC_d = d_v;
    end else if (tick) begin
      regA_d = q_v;
      regB_d = q_v;
      regC_d = q_v;
    end
  end

  // Scrub phase counter: free-running 0..SCRUB_PERIOD-1, independent of loads.
  always_comb begin
    scrub_cnt_d = tick ? '0 : (scrub_cnt_q + SCW'(1));
  end

  // Sticky mismatch flag; a mismatch in the clear cycle keeps it set.
  always_comb begin
    err_flag_d = err_flag_q;
    if (mismatch) begin
      err_flag_d = 1'b1;
    end else if (errClr) begin
      err_flag_d = 1'b0;
    end
  end

  // State registers for copies, scrub phase and flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regA_q      <= '0;
      regB_q      <= '0;
      regC_q      <= '0;
      scrub_cnt_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      regA_q      <= regA_d;
      regB_q      <= regB_d;
      regC_q      <= regC_d;
      scrub_cnt_q <= scrub_cnt_d;
      err_flag_q  <= err_flag_d;
    end
  end

`ifdef TMR_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating mismatch-cycle counter; clear restarts at 1 if still mismatching.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (errClr) begin
      err_cnt_d = mismatch ? CNT_W'(1) : '0;
    end else if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign errCnt = err_cnt_q;
`else
  assign errCnt = '0;
`endif

  assign outA    = q_v;
  assign outB    = q_v;
  assign outC    = q_v;
  assign errFlag = err_flag_q;

endmodule

// File: doc/tmr_scrub_reg.md
# tmr_scrub_reg

Parametrised triplicated register with majority voting, periodic scrubbing and mismatch accounting. It generalises the single-bit, combinational triplicated cell to a WIDTH-bit stateful element. Each copy is refreshed from the voted value on a programmable period, so a single-event upset cannot accumulate into a second copy. It sits between triplicated producer and consumer domains and reports upsets to the slow-control status logic.

## Interface
- WIDTH, 8: data width of each copy.
- SCRUB_PERIOD, 16: cycles between scrub ticks, must be ≥ 2.
- CNT_W, 8: error counter width.
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- inA / inB / inC  in  WIDTH  triplicated data inputs.
- ldA / ldB / ldC  in  1  triplicated load enables.
- errClr  in  1  clears errFlag and errCnt.
- outA / outB / outC  out  WIDTH  voted register value, identical on all three.
- errFlag  out  1  sticky: a copy mismatch has occurred.
- errCnt  out  CNT_W  saturating count of mismatch cycles.

## Operation
- Three internal copies regA/regB/regC.
- ldV = majority(ldA, ldB, ldC). dV = bitwise majority(inA, inB, inC).
- Voted register value qV = bitwise majority(regA, regB, regC). outA/outB/outC are driven combinationally from qV.
- Per-copy next state, in priority order:
  - ldV: dV.
  - Scrub tick: qV.
  - Otherwise: the copy's own value. There is no continuous voted feedback.
- Scrub counter runs 0..SCRUB_PERIOD-1 and wraps to 0. Tick is asserted while the counter is at SCRUB_PERIOD-1. The counter free-runs and is not affected by loads.
- Load coinciding with a tick: the load wins, and all copies take dV.
- Mismatch = any bit where regA, regB and regC are not all equal, evaluated every cycle.
- errFlag:
  - Set on a mismatch cycle.
  - Cleared by errClr.
  - Set wins when both occur in the same cycle.
- errCnt:
  - +1 per mismatch cycle, saturating at 2^CNT_W−1.
  - Cleared to 0 by errClr.
  - A mismatch in the errClr cycle yields 1.
- Reset: all copies 0, scrub counter 0, errFlag 0, errCnt 0. Hence outA/B/C = 0.
- Reset asserted mid-operation clears everything immediately, asynchronously. The scrub phase restarts from 0 after release.

## Timing
- Load latency: ldV sampled at edge N, so outA/B/C = dV after edge N (one cycle).
- Scrub: a corrupted copy is repaired at the first tick edge after the upset. Mismatch duration is at most SCRUB_PERIOD cycles.
- errFlag and errCnt are registered and update one edge after the mismatch cycle.
- A single upset in one copy never changes outA/B/C.

## Configuration
- TMR_ERR_CNT_EN defined: errCnt counter implemented as above.
- Not defined:
  - errCnt is tied to 0 and no counter flops are built.
  - The port remains present.
  - errFlag behaviour is unchanged.

## Structure
- Package tmr_pkg holds:
  - Default constants for WIDTH, SCRUB_PERIOD and CNT_W.
  - A function computing the scrub counter width, clog2(SCRUB_PERIOD).
  - The bitwise majority function.
- One sub-module, tmr_voter: WIDTH-parametrised bitwise 2-of-3 voter. It is instantiated for dV and for qV; ldV uses a WIDTH=1 instance.

## Test plan
Defaults apply unless stated. The bench injects upsets by hierarchical force/release on one copy.
- Reset, then hold all inputs 0 → outA/B/C = 0x00, errFlag = 0, errCnt = 0.
- inA/B/C = 0xA5 with all ld asserted for 1 cycle → outA/B/C = 0xA5 the next cycle. With ldA only → output unchanged; with ldA+ldB → 0xA5.
- Voted inputs: inA = 0xA5, inB = 0xA5, inC = 0x3C with all ld asserted → 0xA5 stored, no mismatch counted.
- Upset repair:
  - Stimulus: after loading 0xA5, pulse-force regB = 0x00 for one cycle, 5 cycles before a tick.
  - Required: outputs stay 0xA5.
  - Required: errFlag = 1.
  - Required: errCnt = 5.
  - Required: after the tick, regB = 0xA5 and the count stops.
- Saturation and clear:
  - Stimulus: CNT_W = 2 with a persistent force on regC.
  - Required: errCnt reaches 3 and holds.
  - Stimulus: assert errClr during a mismatch.
  - Required: errCnt = 1, errFlag = 1.
  - Stimulus: release the force, wait for a tick, then assert errClr.
  - Required: errCnt = 0, errFlag = 0.
- Load coinciding with a tick, and rstn asserted mid-count:
  - Required: the load value is stored.
  - Required: rstn clears all outputs to 0 immediately.
  - Required: after release the first tick occurs SCRUB_PERIOD cycles later.
  - Without TMR_ERR_CNT_EN: errCnt stays 0 throughout.
